mem_ctrl: RTL and testbench

- Memory-side responder for the byte-wide data-port protocol driven by the MEM stage (RWtype / ram_addr / ram_data_o / ram_data_i).
- Also serves the IF stage: assembles 32-bit little-endian instruction words from four byte reads.
- Sole owner of the external single-port byte RAM. The data port has absolute priority; instruction fetch uses idle cycles.

---
 rtl/mem_ctrl.sv | 176 +++++++++++++++++
 tb/tb_mem_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: sole owner of a single-port byte RAM; serves a byte data port (absolute priority)
// and assembles 32-bit instruction fetches in idle cycles. Define MEM_CTRL_PREFETCH_EN for next-word prefetch.
module mem_ctrl #(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        d_rwtype,
    input  logic [31:0]       d_addr,
    input  logic [7:0]        d_wdata,
    output logic [7:0]        d_rdata,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_rdy,
    output logic [31:0]       if_inst,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din
);
    typedef enum logic [2:0] {IDLE, ISSUE0, ISSUE1, ISSUE2, ISSUE3, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [31:0]       buf_q, buf_d, if_inst_q, if_inst_d;
    logic              pend_v_q, pend_v_d, if_rdy_q, if_rdy_d, rd_pend_q, rd_pend_d;
    logic [1:0]        pend_k_q, pend_k_d, issue_k;
    logic [7:0]        d_rdata_q, d_rdata_d;
    logic              data_req, in_issue, in_fetch, issuing;
    logic              unused_hi;

    assign data_req  = d_rwtype == 2'b01 || d_rwtype == 2'b10;
    assign in_issue  = state_q inside {ISSUE0, ISSUE1, ISSUE2, ISSUE3};
    assign in_fetch  = in_issue || state_q == DRAIN;
    assign issuing   = in_issue && !data_req;
    assign issue_k   = 2'(state_q - 3'd1);
    assign unused_hi = ^{d_addr[31:ADDR_W], if_addr[31:ADDR_W]};

    assign ram_a    = !rst ? '0 : data_req ? d_addr[ADDR_W-1:0] : in_issue ? base_q + ADDR_W'(issue_k) : '0;
    assign ram_wr   = rst && d_rwtype == 2'b10;
    assign ram_dout = rst && data_req ? d_wdata : 8'h00;
    // A read returns combinationally in the following cycle, then is held from the register
    assign d_rdata  = rd_pend_q ? ram_din : d_rdata_q;
    assign if_rdy   = if_rdy_q;
    assign if_inst  = if_inst_q;

`ifdef MEM_CTRL_PREFETCH_EN
    logic              pf_mode_q, pf_mode_d, pf_valid_q, pf_valid_d, pf_dirty_q, pf_dirty_d;
    logic [ADDR_W-1:0] pf_addr_q, pf_addr_d, wr_off_pf, wr_off_base;
    logic [31:0]       pf_buf_q, pf_buf_d;
    logic              hit_pf_wr, hit_base_wr, pf_hit;

    // Modular distance from the word base catches writes to any of its four bytes, including wrap
    assign wr_off_pf   = d_addr[ADDR_W-1:0] - pf_addr_q;
    assign wr_off_base = d_addr[ADDR_W-1:0] - base_q;
    assign hit_pf_wr   = d_rwtype == 2'b10 && wr_off_pf < ADDR_W'(4);
    assign hit_base_wr = d_rwtype == 2'b10 && wr_off_base < ADDR_W'(4);
    assign pf_hit      = pf_valid_q && !hit_pf_wr && if_addr[ADDR_W-1:0] == pf_addr_q;
`endif

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        buf_d     = buf_q;
        if_inst_d = if_inst_q;
        if_rdy_d  = 1'b0;
        pend_v_d  = issuing;
        pend_k_d  = issuing ? issue_k : pend_k_q;
        rd_pend_d = d_rwtype == 2'b01;
        d_rdata_d = d_rdata;
        if (pend_v_q) buf_d[{pend_k_q, 3'b000} +: 8] = ram_din;
        if (issuing) state_d = state_t'(state_q + 3'd1);
`ifdef MEM_CTRL_PREFETCH_EN
        pf_mode_d  = pf_mode_q;
        pf_valid_d = pf_valid_q && !hit_pf_wr;
        pf_dirty_d = pf_dirty_q || (pf_mode_q && hit_base_wr);
        pf_addr_d  = pf_addr_q;
        pf_buf_d   = pf_buf_q;
        if (state_q == IDLE && if_req) begin
            pf_valid_d = 1'b0;
            base_d     = pf_hit ? pf_addr_q : if_addr[ADDR_W-1:0];
            buf_d      = '0;
            state_d    = pf_hit ? DONE : ISSUE0;
            if_rdy_d   = pf_hit;
            if_inst_d  = pf_hit ? pf_buf_q : if_inst_q;
        end
        if (state_q == DRAIN && pf_mode_q) begin
            pf_buf_d   = buf_d;
            pf_addr_d  = base_q;
            pf_valid_d = !pf_dirty_d;
            pf_mode_d  = 1'b0;
            state_d    = IDLE;
        end
        if (state_q == DRAIN && !pf_mode_q) begin
            state_d   = DONE;
            if_rdy_d  = 1'b1;
            if_inst_d = buf_d;
        end
        if (state_q == DONE) begin
            state_d    = ISSUE0;
            base_d     = base_q + ADDR_W'(4);
            buf_d      = '0;
            pf_mode_d  = 1'b1;
            pf_dirty_d = 1'b0;
        end
        // A demand request preempts a background prefetch; a dropped request aborts a demand fetch
        if (in_fetch && (pf_mode_q ? if_req : !if_req)) begin
            state_d    = pf_mode_q ? ISSUE0 : IDLE;
            base_d     = pf_mode_q ? if_addr[ADDR_W-1:0] : base_q;
            pf_mode_d  = 1'b0;
            pf_valid_d = 1'b0;
            pend_v_d   = 1'b0;
            buf_d      = '0;
            if_rdy_d   = 1'b0;
            if_inst_d  = if_inst_q;
        end
`else
        if (state_q == IDLE && if_req) begin
            base_d  = if_addr[ADDR_W-1:0];
            buf_d   = '0;
            state_d = ISSUE0;
        end
        if (state_q == DRAIN) begin
            state_d   = DONE;
            if_rdy_d  = 1'b1;
            if_inst_d = buf_d;
        end
        if (state_q == DONE) state_d = IDLE;
        if (in_fetch && !if_req) begin
            state_d   = IDLE;
            pend_v_d  = 1'b0;
            buf_d     = '0;
            if_rdy_d  = 1'b0;
            if_inst_d = if_inst_q;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            base_q    <= '0;
            buf_q     <= '0;
            if_inst_q <= '0;
            if_rdy_q  <= 1'b0;
            pend_v_q  <= 1'b0;
            pend_k_q  <= '0;
            rd_pend_q <= 1'b0;
            d_rdata_q <= '0;
`ifdef MEM_CTRL_PREFETCH_EN
            pf_mode_q  <= 1'b0;
            pf_valid_q <= 1'b0;
            pf_dirty_q <= 1'b0;
            pf_addr_q  <= '0;
            pf_buf_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            buf_q     <= buf_d;
            if_inst_q <= if_inst_d;
            if_rdy_q  <= if_rdy_d;
            pend_v_q  <= pend_v_d;
            pend_k_q  <= pend_k_d;
            rd_pend_q <= rd_pend_d;
            d_rdata_q <= d_rdata_d;
`ifdef MEM_CTRL_PREFETCH_EN
            pf_mode_q  <= pf_mode_d;
            pf_valid_q <= pf_valid_d;
            pf_dirty_q <= pf_dirty_d;
            pf_addr_q  <= pf_addr_d;
            pf_buf_q   <= pf_buf_d;
`endif
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: randomized data-port traffic and instruction fetches against a shadow-memory model
// of expected bytes, instruction words and fetch latency (5 edges plus one per data-port cycle).
module tb_mem_ctrl;
    localparam int AW    = 17;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    d_rwtype;
    logic [31:0]   d_addr, if_addr, if_inst;
    logic [7:0]    d_wdata, d_rdata, ram_dout, ram_din;
    logic          if_req, if_rdy, ram_wr;
    logic [AW-1:0] ram_a;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_rd;
    logic [7:0] mem     [DEPTH];
    logic [7:0] ref_mem [DEPTH];

    always #5 clk = ~clk;

    mem_ctrl #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .d_rwtype(d_rwtype), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .if_req(if_req), .if_addr(if_addr), .if_rdy(if_rdy), .if_inst(if_inst),
        .ram_a(ram_a), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din)
    );

    function automatic logic [7:0] pat(input int a);
        return 8'((a * 37) ^ (a >> 7) ^ 32'h5C);
    endfunction

    function automatic int ix(input logic [31:0] fa, input int k);
        return (int'(fa[AW-1:0]) + k) % DEPTH;
    endfunction

    // External RAM: one-cycle read latency
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = pat(i);
        forever begin
            @(posedge clk);
            ram_din <= mem[ram_a];
            if (ram_wr) mem[ram_a] = ram_dout;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic [1:0] rw, input logic [31:0] a, input logic [7:0] wd,
                       input logic req, input logic [31:0] fa, input logic idle_bus);
        logic [7:0] rd_val;
        d_rwtype = rw; d_addr = a; d_wdata = wd; if_req = req; if_addr = fa;
        #1;
        rd_val = ref_mem[int'(a[AW-1:0])];
        if (rw == 2'd1 || rw == 2'd2) begin
            chk("ram_a", 32'(ram_a), 32'(a[AW-1:0]));
            chk("ram_wr", 32'(ram_wr), 32'(rw == 2'd2));
            if (rw == 2'd2) chk("ram_dout", 32'(ram_dout), 32'(wd));
        end else if (idle_bus) begin
            chk("idle_ram_a", 32'(ram_a), 32'd0);
            chk("idle_ram_wr", 32'(ram_wr), 32'd0);
        end
        if (rw == 2'd2) ref_mem[int'(a[AW-1:0])] = wd;
        @(negedge clk);
        if (rw == 2'd1) exp_rd = rd_val;
        chk("d_rdata", 32'(d_rdata), 32'(exp_rd));
    endtask

    task automatic rnd_op(output logic [1:0] rw, output logic [31:0] a, output logic [7:0] wd);
        int kind = int'($urandom_range(2));
        rw = kind == 0 ? 2'd1 : kind == 1 ? 2'd2 : 2'd3;
        a  = ($urandom & 32'hFFFE_0000) | 32'h1000 | ($urandom & 32'hFFF);
        wd = 8'($urandom);
    endtask

    task automatic fetch(input logic [31:0] fa, input int pct, input logic [15:0] rmask);
        logic [31:0] w, a;
        logic [1:0]  rw;
        logic [7:0]  wd;
        int          issued = 0;
        int          last   = -1;
        bit          done   = 0;
        w = {ref_mem[ix(fa, 3)], ref_mem[ix(fa, 2)], ref_mem[ix(fa, 1)], ref_mem[ix(fa, 0)]};
        cyc(2'd0, 32'd0, 8'd0, 1'b1, fa, 1'b1);
        chk("req_rdy", 32'(if_rdy), 32'd0);
        for (int i = 1; i <= 40 && !done; i++) begin
            rw = 2'd0; a = 32'd0; wd = 8'd0;
            if (i < 16 && rmask[i]) begin rw = 2'd1; a = 32'h100; end
            else if (int'($urandom_range(99)) < pct) rnd_op(rw, a, wd);
            if (!(rw == 2'd1 || rw == 2'd2) && issued < 4) begin
                issued++;
                if (issued == 4) last = i;
            end
            cyc(rw, a, wd, 1'b1, fa, 1'b0);
            chk("if_rdy", 32'(if_rdy), 32'(last >= 0 && i == last + 1));
            if (last >= 0 && i == last + 1) begin
                chk("if_inst", if_inst, w);
                done = 1;
            end
        end
        if (!done) chk("fetch_timeout", 32'd0, 32'd1);
        cyc(2'd0, 32'd0, 8'd0, 1'b0, fa, 1'b0);
        chk("rdy_pulse", 32'(if_rdy), 32'd0);
    endtask

    task automatic abort_fetch(input logic [31:0] fa, input int k);
        cyc(2'd0, 32'd0, 8'd0, 1'b1, fa, 1'b1);
        for (int i = 1; i <= k; i++) begin
            cyc(2'd0, 32'd0, 8'd0, 1'b1, fa, 1'b0);
            chk("abort_rdy_pre", 32'(if_rdy), 32'd0);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(2'd0, 32'd0, 8'd0, 1'b0, fa, i > 0);
            chk("abort_rdy", 32'(if_rdy), 32'd0);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = pat(i);
        rst = 1'b0; d_rwtype = 2'd0; d_addr = 32'd0; d_wdata = 8'd0; if_req = 1'b0; if_addr = 32'd0;
        exp_rd = 8'd0;
        repeat (2) @(negedge clk);
        chk("rst_if_rdy", 32'(if_rdy), 32'd0);
        chk("rst_if_inst", if_inst, 32'd0);
        chk("rst_d_rdata", 32'(d_rdata), 32'd0);
        chk("rst_ram_a", 32'(ram_a), 32'd0);
        chk("rst_ram_wr", 32'(ram_wr), 32'd0);
        rst = 1'b1;
        cyc(2'd2, 32'h10, 8'h13, 1'b0, 32'd0, 1'b1);
        cyc(2'd2, 32'h11, 8'h05, 1'b0, 32'd0, 1'b1);
        cyc(2'd2, 32'h12, 8'h50, 1'b0, 32'd0, 1'b1);
        cyc(2'd2, 32'h13, 8'h00, 1'b0, 32'd0, 1'b1);
        cyc(2'd2, 32'h100, 8'hAB, 1'b0, 32'd0, 1'b1);
        cyc(2'd2, 32'h200, 8'h5A, 1'b0, 32'd0, 1'b1);
        cyc(2'd1, 32'h200, 8'h00, 1'b0, 32'd0, 1'b1);
        chk("wr_then_rd", 32'(d_rdata), 32'h5A);
        cyc(2'd0, 32'd0, 8'd0, 1'b0, 32'd0, 1'b1);
        fetch(32'h10, 0, 16'h0);
        chk("spec_word", if_inst, 32'h0050_0513);
        fetch(32'h10, 0, 16'h000C);
        chk("prio_word", if_inst, 32'h0050_0513);
        chk("prio_rdata", 32'(d_rdata), 32'hAB);
        for (int k = 0; k <= 4; k++) begin
            abort_fetch(32'h80 + 32'(k * 4), k);
            fetch(32'h20, 0, 16'h0);
        end
        cyc(2'd0, 32'd0, 8'd0, 1'b1, 32'h40, 1'b1);
        cyc(2'd0, 32'd0, 8'd0, 1'b1, 32'h40, 1'b0);
        cyc(2'd0, 32'd0, 8'd0, 1'b1, 32'h40, 1'b0);
        chk("pre_rst_ram_a", 32'(ram_a), 32'h42);
        rst = 1'b0;
        #1;
        exp_rd = 8'd0;
        chk("mid_rst_if_rdy", 32'(if_rdy), 32'd0);
        chk("mid_rst_ram_wr", 32'(ram_wr), 32'd0);
        chk("mid_rst_ram_a", 32'(ram_a), 32'd0);
        chk("mid_rst_d_rdata", 32'(d_rdata), 32'd0);
        @(negedge clk);
        rst = 1'b1; if_req = 1'b0;
        fetch(32'h0, 0, 16'h0);
        fetch(32'h0001_FFFC, 30, 16'h0);
        fetch(32'hABCE_0010, 30, 16'h0);
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(3) == 0) abort_fetch($urandom & 32'hFFC, int'($urandom_range(4)));
            fetch(($urandom & 32'hFFC) | (($urandom_range(1) == 1) ? ($urandom & 32'hFFFE_0000) : 32'd0),
                  int'($urandom_range(60)), 16'h0);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
